// File: rtl/jtkicker_objline.sv
// jtkicker_objline: sprite line renderer answering the object scanner's draw/busy handshake.
// Fetches one 16px 4bpp sprite row, maps it through the palette PROM into a double line buffer.
//
// Ports:
//  clk/rst_n       clock, async active-low reset
//  pxl_cen/cen2    pixel enable / half-rate FSM enable
//  LHBL/hinit_x    blanking (active low) / line start
//  hdump           readout position; [7:0] addresses the read bank
//  draw/busy       request handshake
//  code..ysub      sprite request fields
//  prog_*          PROM download port
//  rom_*           SDRAM word fetch
//  pxl             object pixel out, 0 = transparent
module jtkicker_objline #(
  parameter logic       BYPASS_PROM = 1'b0,
  parameter logic [7:0] HOFFSET     = 8'd6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pxl_cen,
  input  logic        cen2,
  input  logic        LHBL,
  input  logic        hinit_x,
  input  logic [8:0]  hdump,
  input  logic        draw,
  output logic        busy,
  input  logic [8:0]  code,
  input  logic [7:0]  xpos,
  input  logic [3:0]  pal,
  input  logic        hflip,
  input  logic        vflip,
  input  logic [3:0]  ysub,
  input  logic [3:0]  prog_data,
  input  logic [7:0]  prog_addr,
  input  logic        prog_en,
  output logic [13:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        rom_cs,
  input  logic        rom_ok,
  output logic [3:0]  pxl
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PAINT
  } state_t;

  state_t      st_q, st_d;
  logic        busy_q, busy_d;
  logic        cs_q, cs_d;
  logic [13:0] addr_q, addr_d;
  logic        half_q, half_d;
  logic        wait_q, wait_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        bank_q, bank_d;
  logic [8:0]  code_q, code_d;
  logic [7:0]  xpos_q, xpos_d;
  logic [3:0]  pal_q, pal_d;
  logic        hflip_q, hflip_d;
  logic        vflip_q, vflip_d;
  logic [3:0]  ysub_q, ysub_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  pxl_q, pxl_d;

  logic [3:0]  prom  [256];
  logic [3:0]  lbuf0 [256];
  logic [3:0]  lbuf1 [256];

  logic [2:0]  col_idx;
  logic [3:0]  pix;
  logic [3:0]  colour;
  logic [7:0]  wr_x;
  logic        paint_we;
  logic        erase_we;
  logic [7:0]  rd_x;
  logic [3:0]  rd_pix;
  logic        take;
  logic        unused_hdump;

  assign unused_hdump = hdump[8];

  // bit 31-c of each byte plane is column c; ~c == 7-c
  always_comb begin
    col_idx  = hflip_q ? ~cnt_q : cnt_q;
    pix      = { data_q[{2'b11, ~col_idx}],
                 data_q[{2'b10, ~col_idx}],
                 data_q[{2'b01, ~col_idx}],
                 data_q[{2'b00, ~col_idx}] };
    colour   = BYPASS_PROM ? pix : prom[{pal_q, pix}];
    wr_x     = xpos_q + HOFFSET + {4'd0, half_q, cnt_q};
    paint_we = (st_q == PAINT) && (colour != 4'd0);
  end

  assign rd_x     = hdump[7:0];
  assign erase_we = pxl_cen & LHBL;
  assign rd_pix   = bank_q ? lbuf0[rd_x] : lbuf1[rd_x];

  always_ff @(posedge clk) begin
    if (prog_en) prom[prog_addr] <= prog_data;
  end

  // each bank sees either the painter or the eraser, never both
  always_ff @(posedge clk) begin
    if (bank_q ? erase_we : paint_we)
      lbuf0[bank_q ? rd_x : wr_x] <= bank_q ? 4'd0 : colour;
  end

  always_ff @(posedge clk) begin
    if (bank_q ? paint_we : erase_we)
      lbuf1[bank_q ? wr_x : rd_x] <= bank_q ? colour : 4'd0;
  end

  always_comb begin
    st_d    = st_q;
    busy_d  = busy_q;
    cs_d    = cs_q;
    addr_d  = addr_q;
    half_d  = half_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    code_d  = code_q;
    xpos_d  = xpos_q;
    pal_d   = pal_q;
    hflip_d = hflip_q;
    vflip_d = vflip_q;
    ysub_d  = ysub_q;
    data_d  = data_q;
    take    = 1'b0;

    unique case (st_q)
      IDLE: take = cen2 & draw;
      FETCH: begin
        // wait_q swallows an rom_ok left over from the previous address
        if (cen2) begin
          if (wait_q) begin
            wait_d = 1'b0;
          end else if (rom_ok) begin
            data_d = rom_data;
            st_d   = PAINT;
            cs_d   = 1'b0;
            cnt_d  = 3'd0;
          end
        end
      end
      PAINT: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          if (!half_q) begin
            half_d = 1'b1;
            st_d   = FETCH;
            cs_d   = 1'b1;
            wait_d = 1'b1;
            addr_d = {code_q, ~hflip_q,
                      ysub_q ^ {4{vflip_q}}};
          end else begin
            st_d   = IDLE;
            busy_d = 1'b0;
          end
        end
      end
      default: st_d = IDLE;
    endcase

    if (cen2 && hinit_x) begin
      bank_d = ~bank_q;
      st_d   = IDLE;
      busy_d = 1'b0;
      cs_d   = 1'b0;
      wait_d = 1'b0;
      take   = draw;
    end

    if (take) begin
      code_d  = code;
      xpos_d  = xpos;
      pal_d   = pal;
      hflip_d = hflip;
      vflip_d = vflip;
      ysub_d  = ysub;
      st_d    = FETCH;
      busy_d  = 1'b1;
      half_d  = 1'b0;
      cs_d    = 1'b1;
      wait_d  = 1'b1;
      addr_d  = {code, hflip, ysub ^ {4{vflip}}};
    end
  end

  always_comb begin
    pxl_d = pxl_q;
    if (pxl_cen) pxl_d = LHBL ? rd_pix : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      busy_q  <= 1'b0;
      cs_q    <= 1'b0;
      addr_q  <= 14'd0;
      half_q  <= 1'b0;
      wait_q  <= 1'b0;
      cnt_q   <= 3'd0;
      bank_q  <= 1'b0;
      code_q  <= 9'd0;
      xpos_q  <= 8'd0;
      pal_q   <= 4'd0;
      hflip_q <= 1'b0;
      vflip_q <= 1'b0;
      ysub_q  <= 4'd0;
      data_q  <= 32'd0;
      pxl_q   <= 4'd0;
    end else begin
      st_q    <= st_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      half_q  <= half_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      code_q  <= code_d;
      xpos_q  <= xpos_d;
      pal_q   <= pal_d;
      hflip_q <= hflip_d;
      vflip_q <= vflip_d;
      ysub_q  <= ysub_d;
      data_q  <= data_d;
      pxl_q   <= pxl_d;
    end
  end

  assign busy     = busy_q;
  assign rom_cs   = cs_q;
  assign rom_addr = addr_q;
  assign pxl      = pxl_q;

endmodule

// File: tb/tb_jtkicker_objline.sv
// tb_jtkicker_objline: directed bench for the sprite line renderer.
// Vector table of sprite requests plus hand sequences for stalls, aborts and reset.
module tb_jtkicker_objline;

  logic        clk, rst_n, pxl_cen, cen2, LHBL, hinit_x;
  logic [8:0]  hdump;
  logic        draw, busy;
  logic [8:0]  code;
  logic [7:0]  xpos;
  logic [3:0]  pal;
  logic        hflip, vflip;
  logic [3:0]  ysub;
  logic [3:0]  prog_data;
  logic [7:0]  prog_addr;
  logic        prog_en;
  logic [13:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_cs, rom_ok;
  logic [3:0]  pxl;
  logic        ok_en;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [8:0]  code;
    logic [7:0]  xpos;
    logic [3:0]  pal;
    logic        hflip;
    logic        vflip;
    logic [3:0]  ysub;
    logic [13:0] a1;
    logic [13:0] a2;
    bit          last;
  } vec_t;

  vec_t       vec [5];
  logic [3:0] prom_m   [256];
  logic [3:0] exp_line [256];
  logic [13:0] addr_log [$];
  logic        prev_cs = 1'b0;
  logic [13:0] prev_addr = 14'd0;

  jtkicker_objline dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .cen2(cen2),
    .LHBL(LHBL), .hinit_x(hinit_x), .hdump(hdump), .draw(draw),
    .busy(busy), .code(code), .xpos(xpos), .pal(pal),
    .hflip(hflip), .vflip(vflip), .ysub(ysub),
    .prog_data(prog_data), .prog_addr(prog_addr), .prog_en(prog_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_cs(rom_cs),
    .rom_ok(rom_ok), .pxl(pxl)
  );

  function automatic logic [31:0] rom_word(input logic [13:0] a);
    logic [31:0] w;
    if (a[13:5] == 9'h1FF) return 32'h00FF00FF;
    w = (32'(a) + 32'd1) * 32'h9E3779B9;
    return w ^ (w >> 13);
  endfunction

  assign rom_data = rom_word(rom_addr);
  assign rom_ok   = rom_cs & ok_en;

  initial begin
    clk = 1'b0;
    cen2 = 1'b0;
    forever begin
      #5 clk = 1'b1;
      #5 clk = 1'b0;
      cen2 = ~cen2;
    end
  end

  always @(negedge clk) begin
    if (rom_cs && (!prev_cs || rom_addr != prev_addr))
      addr_log.push_back(rom_addr);
    prev_cs   <= rom_cs;
    prev_addr <= rom_addr;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic sync_cen2();
    do begin
      @(negedge clk); #1;
    end while (!cen2);
  endtask

  task automatic set_req(input vec_t v);
    code = v.code; xpos = v.xpos; pal = v.pal;
    hflip = v.hflip; vflip = v.vflip; ysub = v.ysub;
  endtask

  task automatic do_draw(input vec_t v);
    sync_cen2();
    set_req(v);
    draw = 1'b1;
    @(posedge clk); #1;
    draw = 1'b0;
  endtask

  task automatic toggle();
    sync_cen2();
    hinit_x = 1'b1;
    @(posedge clk); #1;
    hinit_x = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic sweep(input bit do_chk, input bit zero);
    for (int k = 0; k <= 256; k++) begin
      @(negedge clk); #1;
      if (k == 0) begin
        LHBL = 1'b1;
        pxl_cen = 1'b1;
      end
      if (k > 0 && do_chk)
        chk(zero ? "erased" : "pxl", pxl,
            zero ? 0 : exp_line[k-1]);
      if (k < 256) hdump = 9'(k);
    end
    LHBL = 1'b0;
    pxl_cen = 1'b0;
  endtask

  task automatic model_paint(input vec_t v);
    logic [13:0] la, ra;
    logic [31:0] w;
    logic [3:0]  p, c;
    int s, b, x;
    la = v.hflip ? v.a2 : v.a1;
    ra = v.hflip ? v.a1 : v.a2;
    for (int k = 0; k < 16; k++) begin
      s = v.hflip ? 15 - k : k;
      w = rom_word(s < 8 ? la : ra);
      b = s % 8;
      p = {w[31-b], w[23-b], w[15-b], w[7-b]};
      c = prom_m[{v.pal, p}];
      x = (int'(v.xpos) + 6 + k) % 256;
      if (c != 4'd0) exp_line[x] = c;
    end
  endtask

  task automatic probe_blank();
    int fx = -1;
    for (int k = 0; k < 256; k++)
      if (fx < 0 && exp_line[k] != 4'd0) fx = k;
    if (fx >= 0) begin
      @(negedge clk); #1;
      LHBL = 1'b0;
      pxl_cen = 1'b1;
      hdump = 9'(fx);
      @(negedge clk); #1;
      chk("blank_pxl", pxl, 0);
      pxl_cen = 1'b0;
    end
  endtask

  task automatic finish_line();
    toggle();
    probe_blank();
    sweep(1'b1, 1'b0);
    sweep(1'b1, 1'b1);
    for (int k = 0; k < 256; k++) exp_line[k] = 4'd0;
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    addr_log.delete();
    ok_en = (hold == 0);
    do_draw(v);
    chk("busy_set", busy, 1);
    repeat (hold) begin
      @(negedge clk); #1;
      chk("hold_cs", rom_cs, 1);
      chk("hold_addr", rom_addr, v.a1);
    end
    ok_en = 1'b1;
    wait_idle();
    chk("n_fetch", addr_log.size(), 2);
    if (addr_log.size() >= 1) chk("addr1", addr_log[0], v.a1);
    if (addr_log.size() >= 2) chk("addr2", addr_log[1], v.a2);
    model_paint(v);
    if (v.last) finish_line();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; pxl_cen = 1'b0; LHBL = 1'b0; hinit_x = 1'b0;
    hdump = 9'd0; draw = 1'b0; code = 9'd0; xpos = 8'd0;
    pal = 4'd0; hflip = 1'b0; vflip = 1'b0; ysub = 4'd0;
    prog_data = 4'd0; prog_addr = 8'd0; prog_en = 1'b0; ok_en = 1'b1;
    for (int k = 0; k < 256; k++) exp_line[k] = 4'd0;

    vec[0] = '{9'h155, 8'd16,  4'd0, 1'b0, 1'b0, 4'd3, 14'h2AA3, 14'h2AB3, 1'b1};
    vec[1] = '{9'h155, 8'd16,  4'd0, 1'b1, 1'b1, 4'd3, 14'h2ABC, 14'h2AAC, 1'b1};
    vec[2] = '{9'h1FF, 8'd244, 4'd0, 1'b0, 1'b0, 4'd0, 14'h3FE0, 14'h3FF0, 1'b1};
    vec[3] = '{9'h0A3, 8'd100, 4'd7, 1'b1, 1'b0, 4'd9, 14'h1479, 14'h1469, 1'b0};
    vec[4] = '{9'h011, 8'd108, 4'd2, 1'b0, 1'b1, 4'd5, 14'h022A, 14'h023A, 1'b1};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cs", rom_cs, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_pxl", pxl, 0);
    rst_n = 1'b1;

    for (int a = 0; a < 256; a++) begin
      prom_m[a] = 4'(a) ^ 4'(a >> 4);
      @(negedge clk); #1;
      prog_en = 1'b1;
      prog_addr = 8'(a);
      prog_data = prom_m[a];
    end
    @(negedge clk); #1;
    prog_en = 1'b0;

    sweep(1'b0, 1'b0);
    toggle();
    sweep(1'b0, 1'b0);

    for (int i = 0; i < 5; i++) run_vec(vec[i], 0);

    run_vec(vec[0], 20);

    // second draw while busy is dropped, then abort mid-paint
    addr_log.delete();
    ok_en = 1'b0;
    do_draw(vec[3]);
    repeat (3) @(negedge clk);
    do_draw(vec[4]);
    repeat (2) @(negedge clk);
    #1;
    chk("ign_busy", busy, 1);
    chk("ign_addr", rom_addr, vec[3].a1);
    ok_en = 1'b1;
    n = 0;
    while (rom_cs && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("paint_reached", rom_cs, 0);
    chk("paint_busy", busy, 1);
    toggle();
    chk("abort_busy", busy, 0);
    chk("abort_cs", rom_cs, 0);
    sweep(1'b0, 1'b0);

    // draw coinciding with hinit_x is taken after the abort
    ok_en = 1'b0;
    do_draw(vec[0]);
    repeat (2) @(negedge clk);
    sync_cen2();
    set_req(vec[1]);
    hinit_x = 1'b1;
    draw = 1'b1;
    @(posedge clk); #1;
    hinit_x = 1'b0;
    draw = 1'b0;
    chk("hd_busy", busy, 1);
    chk("hd_addr", rom_addr, vec[1].a1);
    ok_en = 1'b1;
    wait_idle();
    model_paint(vec[1]);
    finish_line();

    // asynchronous reset while fetching
    ok_en = 1'b0;
    do_draw(vec[2]);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cs", rom_cs, 0);
    chk("arst_addr", rom_addr, 0);
    chk("arst_pxl", pxl, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    ok_en = 1'b1;
    run_vec(vec[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
